// File: rtl/pw_slot_saver.sv
// Password-slot saver: scans the slot store for the first empty slot and writes
// the latched password there, aborting on a full store or (optionally) a duplicate.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for start; outputs hold last addresses/err_code
// S_SCAN  | one slot per cycle, looking for duplicates and first empty
// S_WRITE | save_start strobe to the store
// S_DONE  | finish pulse
// S_ERR   | error pulse, err_code already set
module pw_slot_saver #(
    parameter int NUM_SLOTS = 4,
    parameter int ADDR_W    = 2,
    parameter int PW_WIDTH  = 16,
    parameter int CHECK_DUP = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [PW_WIDTH-1:0] pw_in,
    input  logic [PW_WIDTH:0]   slot_data,
    output logic [ADDR_W-1:0]   read_addr,
    output logic [ADDR_W-1:0]   save_addr,
    output logic [PW_WIDTH-1:0] save_data,
    output logic                save_start,
    output logic                finish,
    output logic                error,
    output logic [1:0]          err_code,
    output logic                busy
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_SLOTS - 1);
    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_DUP  = 2'b01;
    localparam logic [1:0] ERR_FULL = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_t;

    state_t state, state_nxt;
    logic   found;
    logic   slot_valid;
    logic   dup_hit;
    logic   empty_hit;
    logic   last_slot;

    always_comb begin
        slot_valid = slot_data[PW_WIDTH];
        // Only valid slots count as duplicates; stale bits in an empty slot are ignored.
        dup_hit    = (CHECK_DUP != 0) && slot_valid && (slot_data[PW_WIDTH-1:0] == save_data);
        empty_hit  = !slot_valid && !found;
        last_slot  = (read_addr == LAST_ADDR);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        save_start = 1'b0;
        finish     = 1'b0;
        error      = 1'b0;
        busy       = 1'b1;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = S_SCAN;
                end
            end
            S_SCAN: begin
                if (dup_hit) begin
                    state_nxt = S_ERR;
                end else if (last_slot) begin
                    state_nxt = (found || empty_hit) ? S_WRITE : S_ERR;
                end
            end
            S_WRITE: begin
                save_start = 1'b1;
                state_nxt  = S_DONE;
            end
            S_DONE: begin
                finish    = 1'b1;
                state_nxt = S_IDLE;
            end
            S_ERR: begin
                error     = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            read_addr <= '0;
            save_addr <= '0;
            save_data <= '0;
            err_code  <= ERR_NONE;
            found     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        save_data <= pw_in;
                        read_addr <= '0;
                        err_code  <= ERR_NONE;
                        found     <= 1'b0;
                    end
                end
                S_SCAN: begin
                    if (dup_hit) begin
                        err_code <= ERR_DUP;
                    end else begin
                        if (empty_hit) begin
                            save_addr <= read_addr;
                            found     <= 1'b1;
                        end
                        // read_addr parks on the last slot rather than wrapping.
                        if (last_slot) begin
                            if (!(found || empty_hit)) begin
                                err_code <= ERR_FULL;
                            end
                        end else begin
                            read_addr <= read_addr + ADDR_W'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
